hb_out_capture: RTL and testbench
=================================

Name: hb_out_capture

Overview:
- Downstream neighbour of the time-multiplexed half-band filter. Captures the filter's 16-bit output once per 5-clock sample frame (153.6 MHz / 30.72 MS/s) at a programmable phase.
- Optionally decimates by 2 (15.36 MS/s) and discards the pipeline-fill samples after reset.
- Buffers results in a small first-word-fall-through (FWFT) FIFO with valid/ready output and a sticky overflow flag.
- Feeds the next baseband stage.

Parameters:
- CAPTURE_PHASE, 2, frame phase (0..4) at which y_in is sampled.
- FLUSH_CNT, 4, number of captures discarded after reset. 0 disables discard.
- DEPTH, 8, FIFO depth. Power of 2, at least 2.

Ports:
- clk_153p6MHz  in  1  system clock, 153.6 MHz.
- reset  in  1  synchronous, active-low.
- frame_sync  in  1  pulse marking phase 0 of the filter's 5-cycle frame.
- y_in  in  16  filter output, signed two's complement.
- decim_en  in  1  1 = keep every second capture; 0 = keep all captures.
- clear_ovf  in  1  clears the sticky overflow flag.
- m_ready  in  1  downstream accept.
- m_valid  out  1  FIFO non-empty.
- m_data  out  16  FIFO head sample.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset and clock (already decided): reset is synchronous, active-low, named reset; clock is clk_153p6MHz. All state updates on the rising edge.
- Reset values: ph=0, flush_cnt=FLUSH_CNT, dec_tog=0, FIFO pointers 0, fifo_level=0, m_valid=0, m_data=0, overflow=0.
- Phase counter ph:
  - Counts 0,1,2,3,4,0...
  - frame_sync=1 forces ph<=1 on the next edge, so the frame_sync cycle is phase 0.
  - frame_sync has priority over normal wrap.
  - frame_sync while ph is already 0 is harmless.
- Capture strobe cap = (ph==CAPTURE_PHASE). y_in is sampled combinationally on that cycle. Exactly one cap per 5 cycles while in sync.
- Flush:
  - While flush_cnt != 0, each cap decrements flush_cnt and the sample is discarded.
  - Discarded captures do not toggle dec_tog.
- Decimation:
  - decim_en=0: every post-flush cap is kept; dec_tog is held at 0.
  - decim_en=1: the sample is kept when dec_tog==0; dec_tog toggles on every post-flush cap. The first post-flush capture is therefore kept.
  - Changing decim_en mid-stream takes effect at the next cap.
- FIFO write (wr) = kept capture. FIFO read (rd) = m_valid & m_ready.
  - Not full: write stores at wr_ptr, wr_ptr increments modulo DEPTH.
  - Full with rd in the same cycle: both happen, level unchanged, no overflow.
  - Full without rd: the new sample is dropped, overflow<=1, pointers unchanged.
  - Empty: rd cannot occur because m_valid=0. A wr into an empty FIFO makes m_valid=1 on the next cycle (1-cycle latency from cap to m_valid).
- fifo_level: +1 on wr only, -1 on rd only, unchanged on both or neither.
- Outputs: m_valid = (fifo_level != 0). m_data = mem[rd_ptr] when m_valid, else 0.
- m_data must stay stable while m_valid=1 and m_ready=0.
- Overflow: set has priority over clear_ovf in the same cycle. Otherwise clear_ovf=1 clears it.
- Latency:
  - y_in at the capture cycle appears on m_data one cycle later, if the FIFO was empty.
  - Throughput: 1 sample per 5 clocks (decim_en=0) or per 10 clocks (decim_en=1).
- Reset asserted mid-operation: all FIFO contents are lost, flush restarts, m_valid drops the cycle after reset is sampled low.

Decomposition:
- Shared package hb_pkg holds:
  - SAMPLE_W=16.
  - FRAME_LEN=5 (153.6 MHz / 30.72 MS/s).
  - the phase-counter width.
- One natural sub-module: hb_sync_fifo (FWFT, DEPTH/width parameters, wr/rd/full/empty/level, same clock and reset).

Test Plan:
- Flush and capture: FLUSH_CNT=4, decim_en=0, m_ready=1, frame_sync at cycle 0, y_in = cycle index. Required: captures 1-4 (cycles 2,7,12,17) are dropped; m_data=22 with m_valid at cycle 23, then 27, 32, ... every 5 cycles.
- Decimation: same setup with decim_en=1. Required: kept values 22, 32, 42 appear at 10-cycle spacing; 27 and 37 never appear.
- Resync: frame_sync pulsed at cycle 51 (mid-frame). Required: the next capture is at cycle 53 with value 53 on m_data at cycle 54; the old cycle-52 capture does not occur.
- Backpressure and overflow: m_ready=0, DEPTH=8, decim_en=0. Required: fifo_level reaches 8 after 8 kept captures; the 9th kept capture is dropped and overflow=1. Then with m_ready=1, the drained data equals the first 8 values in order. overflow stays 1 until clear_ovf.
- Full with simultaneous read/write: FIFO full, m_ready=1 exactly on a cap cycle. Required: level stays 8, overflow stays 0, head advances by one.
- Overflow priority and reset: clear_ovf=1 on the same cycle as a dropped write leaves overflow=1. Asserting reset (0) mid-stream gives m_valid=0 and fifo_level=0 on the next cycle, and the flush of 4 captures restarts.

Source files
------------

// File: rtl/hb_pkg.sv
// ----------------------------------------------------------------------------
// hb_pkg
// Shared constants for the half-band output path.
//   SAMPLE_W  : width of one baseband sample (signed two's complement)
//   FRAME_LEN : clocks per sample frame (153.6 MHz / 30.72 MS/s)
//   PH_W      : width of the frame phase counter
// ----------------------------------------------------------------------------
package hb_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int FRAME_LEN = 5;
    localparam int PH_W      = $clog2(FRAME_LEN);

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [PH_W-1:0]     phase_t;

    // Next frame phase: frame_sync marks phase 0 of the current cycle, so the
    // following cycle is phase 1. Sync wins over the normal wrap.
    function automatic phase_t next_phase(input phase_t ph, input logic sync);
        if (sync)
            return phase_t'(1);
        else if (ph == phase_t'(FRAME_LEN - 1))
            return '0;
        else
            return ph + phase_t'(1);
    endfunction

endpackage

// File: rtl/hb_sync_fifo.sv
// ----------------------------------------------------------------------------
// hb_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever the FIFO is non-empty (zero otherwise).
//   clk_153p6MHz : clock
//   reset        : synchronous, active-low
//   wr / wr_data : write request and data; accepted when not full, or when
//                  full and a read happens in the same cycle
//   rd           : pop the head entry (ignored when empty)
//   rd_data      : head entry, 0 when empty
//   full / empty : occupancy flags
//   level        : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module hb_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk_153p6MHz,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    // A write into a full FIFO only succeeds if the head leaves the same cycle.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_153p6MHz) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_ok && !rd_ok)
                level <= level + LVL_W'(1);
            else if (rd_ok && !wr_ok)
                level <= level - LVL_W'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // level define which entries are meaningful, so stale contents are never seen.
    always_ff @(posedge clk_153p6MHz) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/hb_out_capture.sv
// ----------------------------------------------------------------------------
// hb_out_capture
// Samples the time-multiplexed half-band filter output once per 5-clock frame
// at CAPTURE_PHASE, discards the first FLUSH_CNT captures after reset
// (pipeline fill), optionally keeps only every second capture, and buffers the
// kept samples in a FWFT FIFO with valid/ready output.
//   clk_153p6MHz : 153.6 MHz system clock
//   reset        : synchronous, active-low
//   frame_sync   : pulse marking phase 0 of the filter frame
//   y_in         : filter output sample
//   decim_en     : 1 = keep every second capture, 0 = keep all
//   clear_ovf    : clears the sticky overflow flag
//   m_ready      : downstream accept
//   m_valid      : FIFO non-empty
//   m_data       : FIFO head sample (0 when empty)
//   fifo_level   : FIFO occupancy
//   overflow     : sticky, a kept sample was dropped on a full FIFO
// ----------------------------------------------------------------------------
module hb_out_capture
    import hb_pkg::*;
#(
    parameter int CAPTURE_PHASE = 2,
    parameter int FLUSH_CNT     = 4,
    parameter int DEPTH         = 8
) (
    input  logic                    clk_153p6MHz,
    input  logic                    reset,
    input  logic                    frame_sync,
    input  logic [SAMPLE_W-1:0]     y_in,
    input  logic                    decim_en,
    input  logic                    clear_ovf,
    input  logic                    m_ready,
    output logic                    m_valid,
    output logic [SAMPLE_W-1:0]     m_data,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow
);

    localparam int FL_W = (FLUSH_CNT > 0) ? $clog2(FLUSH_CNT + 1) : 1;

    phase_t          ph;
    logic [FL_W-1:0] flush_cnt;
    logic            dec_tog;

    logic cap;
    logic post_cap;
    logic keep;
    logic rd;
    logic fifo_full;
    logic fifo_empty;
    logic ovf_set;

    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves a signal unassigned (which would infer a latch).
    always_comb begin
        cap      = 1'b0;
        post_cap = 1'b0;
        keep     = 1'b0;
        cap      = (ph == phase_t'(CAPTURE_PHASE));
        post_cap = cap && (flush_cnt == '0);
        // With decimation on, the first post-flush capture (dec_tog==0) is kept.
        keep     = post_cap && (!decim_en || !dec_tog);
    end

    assign rd      = m_valid & m_ready;
    assign ovf_set = keep & fifo_full & ~rd;

    always_ff @(posedge clk_153p6MHz) begin
        if (!reset) begin
            ph        <= '0;
            flush_cnt <= FL_W'(FLUSH_CNT);
            dec_tog   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ph <= next_phase(ph, frame_sync);

            // Discarded fill captures neither reach the FIFO nor touch dec_tog.
            if (cap && flush_cnt != '0)
                flush_cnt <= flush_cnt - FL_W'(1);

            if (post_cap)
                dec_tog <= decim_en ? ~dec_tog : 1'b0;

            // A drop in the same cycle as clear_ovf keeps the flag set.
            if (ovf_set)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

    hb_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_153p6MHz (clk_153p6MHz),
        .reset        (reset),
        .wr           (keep),
        .wr_data      (y_in),
        .rd           (rd),
        .rd_data      (m_data),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .level        (fifo_level)
    );

    assign m_valid = ~fifo_empty;

endmodule

// File: tb/tb_hb_out_capture.sv
// ----------------------------------------------------------------------------
// tb_hb_out_capture
// Directed, table-driven bench. Each scenario starts from reset, pulses
// frame_sync at cycle 0 and drives y_in = cycle index. Table rows hold the
// expected outputs at given cycles of a given scenario.
//   1: flush + capture, then a mid-frame resync at cycle 51
//   2: decimation by 2
//   3: backpressure, overflow, clear priority, full read+write, drain
//   4: reset asserted mid-stream, flush restarts
// ----------------------------------------------------------------------------
module tb_hb_out_capture;

    logic        clk_153p6MHz = 1'b0;
    logic        reset;
    logic        frame_sync;
    logic [15:0] y_in;
    logic        decim_en;
    logic        clear_ovf;
    logic        m_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic [3:0]  fifo_level;
    logic        overflow;

    always #5 clk_153p6MHz = ~clk_153p6MHz;

    hb_out_capture #(
        .CAPTURE_PHASE (2),
        .FLUSH_CNT     (4),
        .DEPTH         (8)
    ) dut (
        .clk_153p6MHz (clk_153p6MHz),
        .reset        (reset),
        .frame_sync   (frame_sync),
        .y_in         (y_in),
        .decim_en     (decim_en),
        .clear_ovf    (clear_ovf),
        .m_ready      (m_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    typedef enum int {K_VD, K_LVL, K_OVF} kind_e;

    // K_VD: a = m_valid, b = m_data; K_LVL: a = fifo_level; K_OVF: a = overflow
    typedef struct {
        int          tst;
        int          cyc;
        kind_e       kind;
        logic [15:0] a;
        logic [15:0] b;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic add(input int tst, input int cyc, input kind_e kind,
                       input int a, input int b);
        vec_t v;
        v.tst  = tst;
        v.cyc  = cyc;
        v.kind = kind;
        v.a    = 16'(a);
        v.b    = 16'(b);
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk_153p6MHz);
        #1;
    endtask

    function automatic logic ready_for(input int tst, input int c);
        case (tst)
            3:       return (c == 72) || (c >= 74);
            4:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic clear_for(input int tst, input int c);
        return (tst == 3) && ((c == 67) || (c == 69));
    endfunction

    // Outputs are checked 1 time unit after the edge that opens cycle c,
    // then the inputs for cycle c are driven.
    task automatic run_stream(input int tst, input int ncyc, input logic decim,
                              input int fs2, input int rst_at);
        logic bad_seen;
        reset      = 1'b0;
        frame_sync = 1'b0;
        clear_ovf  = 1'b0;
        m_ready    = 1'b0;
        y_in       = '0;
        decim_en   = decim;
        step();
        step();
        bad_seen = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            foreach (tbl[i]) begin
                if (tbl[i].tst == tst && tbl[i].cyc == c) begin
                    case (tbl[i].kind)
                        K_VD: begin
                            check($sformatf("t%0d_valid", tst), c, 32'(m_valid), 32'(tbl[i].a[0]));
                            check($sformatf("t%0d_data", tst), c, 32'(m_data), 32'(tbl[i].b));
                        end
                        K_LVL: check($sformatf("t%0d_level", tst), c, 32'(fifo_level), 32'(tbl[i].a));
                        K_OVF: check($sformatf("t%0d_overflow", tst), c, 32'(overflow), 32'(tbl[i].a[0]));
                        default: ;
                    endcase
                end
            end
            if (m_valid && (m_data == 16'd27 || m_data == 16'd37))
                bad_seen = 1'b1;
            reset      = (c == rst_at) ? 1'b0 : 1'b1;
            frame_sync = (c == 0) || (c == fs2);
            y_in       = 16'(c);
            m_ready    = ready_for(tst, c);
            clear_ovf  = clear_for(tst, c);
            step();
        end
        if (tst == 2)
            check("t2_odd_kept_absent", ncyc, 32'(bad_seen), 32'd0);
    endtask

    initial begin
        // Scenario 1: flush of 4 (caps 2,7,12,17), first output 22 at 23,
        // resync at 51 removes the cap at 52 and moves it to 53.
        add(1, 0,  K_VD, 0, 0);  add(1, 0, K_LVL, 0, 0);  add(1, 0, K_OVF, 0, 0);
        add(1, 3,  K_VD, 0, 0);  add(1, 8,  K_VD, 0, 0);
        add(1, 13, K_VD, 0, 0);  add(1, 18, K_VD, 0, 0);
        add(1, 22, K_VD, 0, 0);  add(1, 23, K_VD, 1, 22); add(1, 23, K_LVL, 1, 0);
        add(1, 24, K_VD, 0, 0);  add(1, 28, K_VD, 1, 27);
        add(1, 33, K_VD, 1, 32); add(1, 48, K_VD, 1, 47);
        add(1, 53, K_VD, 0, 0);  add(1, 54, K_VD, 1, 53);
        add(1, 59, K_VD, 1, 58);

        // Scenario 2: decimation keeps 22, 32, 42.
        add(2, 0,  K_VD, 0, 0);
        add(2, 23, K_VD, 1, 22); add(2, 28, K_VD, 0, 0);
        add(2, 33, K_VD, 1, 32); add(2, 38, K_VD, 0, 0);
        add(2, 43, K_VD, 1, 42);

        // Scenario 3: fill 22..57, drop 62, clear collides with drop at 67,
        // clean clear at 69, read+write while full at 72, drain from 74.
        add(3, 57, K_LVL, 7, 0); add(3, 58, K_LVL, 8, 0); add(3, 58, K_OVF, 0, 0);
        add(3, 58, K_VD, 1, 22);
        add(3, 63, K_OVF, 1, 0); add(3, 63, K_LVL, 8, 0); add(3, 63, K_VD, 1, 22);
        add(3, 66, K_OVF, 1, 0); add(3, 68, K_OVF, 1, 0);
        add(3, 70, K_OVF, 0, 0); add(3, 70, K_VD, 1, 22);
        add(3, 73, K_LVL, 8, 0); add(3, 73, K_OVF, 0, 0); add(3, 73, K_VD, 1, 27);
        add(3, 74, K_VD, 1, 27); add(3, 75, K_VD, 1, 32); add(3, 76, K_VD, 1, 37);
        add(3, 77, K_VD, 1, 42); add(3, 78, K_VD, 1, 47); add(3, 79, K_VD, 1, 52);
        add(3, 80, K_VD, 1, 57); add(3, 81, K_VD, 1, 72); add(3, 82, K_VD, 1, 77);

        // Scenario 4: reset at 30; caps 33,38,43,48 flushed, 53 kept.
        add(4, 28, K_VD, 1, 22); add(4, 30, K_LVL, 2, 0);
        add(4, 31, K_VD, 0, 0);  add(4, 31, K_LVL, 0, 0); add(4, 31, K_OVF, 0, 0);
        add(4, 53, K_LVL, 0, 0);
        add(4, 54, K_VD, 1, 53); add(4, 54, K_LVL, 1, 0);

        run_stream(1, 62, 1'b0, 51, -1);
        run_stream(2, 50, 1'b1, -1, -1);
        run_stream(3, 84, 1'b0, -1, -1);
        run_stream(4, 56, 1'b0, -1, 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
